// File: rtl/rs232out_fifo.sv
// Transmit FIFO feeding rs232out over its we/busy handshake, one hand-off per character.
// Optional feature: define RS232OUT_FIFO_CRLF_EN to expand each LF into a CR/LF pair.
module rs232out_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            tx_data,
    output logic                  tx_we,
    input  logic                  tx_busy
);

    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT
    } state_t;

    state_t              state, state_next;
    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0] wr_ptr_next, rd_ptr_next, level_next;
    logic [7:0]          head, launch_data;
    logic                push, pop, launch;

`ifdef RS232OUT_FIFO_CRLF_EN
    logic cr_pending, cr_set, cr_clr;
`endif

    assign head = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // wr_full is registered, so a pop in this same cycle cannot make room for a write.
    assign push        = wr_valid & ~wr_full;
    assign wr_ptr_next = wr_ptr + {{DEPTH_LOG2{1'b0}}, push};
    assign rd_ptr_next = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop};
    assign level_next  = wr_ptr_next - rd_ptr_next;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (latch).
    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        pop         = 1'b0;
        launch_data = head;
`ifdef RS232OUT_FIFO_CRLF_EN
        cr_set      = 1'b0;
        cr_clr      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (level != '0 && !tx_busy) begin
                    launch     = 1'b1;
                    state_next = HOLD;
`ifdef RS232OUT_FIFO_CRLF_EN
                    if (head == 8'h0A && !cr_pending) begin
                        launch_data = 8'h0D;
                        cr_set      = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        cr_clr = cr_pending;
                    end
`else
                    pop = 1'b1;
`endif
                end
            end
            // rs232out raises busy only the cycle after it samples we, so busy is not trusted here.
            HOLD:    state_next = WAIT;
            WAIT:    if (!tx_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_full  <= 1'b0;
            overflow <= 1'b0;
            tx_we    <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state   <= state_next;
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            level   <= level_next;
            wr_full <= (level_next == FULL_LEVEL);
            tx_we   <= launch;
            if (launch) tx_data <= launch_data;
            if (wr_valid && wr_full) overflow <= 1'b1;
        end
    end

`ifdef RS232OUT_FIFO_CRLF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    cr_pending <= 1'b0;
        else if (cr_set) cr_pending <= 1'b1;
        else if (cr_clr) cr_pending <= 1'b0;
    end
`endif

    // NOTE: the storage array has no reset; pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_rs232out_fifo.sv
// Directed self-checking bench for rs232out_fifo with an rs232out-like busy model.
// Expected CR/LF behaviour follows RS232OUT_FIFO_CRLF_EN.
module tb_rs232out_fifo;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_full;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_busy;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // Busy model: busy rises the cycle after we is sampled and lasts busy_len cycles.
    logic hold_busy = 1'b0;
    int   busy_len = 4;
    int   busy_cnt = 0;
    assign tx_busy = hold_busy | (busy_cnt != 0);

    logic [7:0] pulse_data[$];
    int         pulse_cyc[$];
    logic       prev_we = 1'b0;
    int         consec_err = 0;
    int         busy_err = 0;

    rs232out_fifo #(.DEPTH_LOG2(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_full  (wr_full),
        .level    (level),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_busy  (tx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (tx_we)              busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clock) begin
        if (reset_n && tx_we) begin
            pulse_data.push_back(tx_data);
            pulse_cyc.push_back(cycle);
            if (prev_we) consec_err++;
            if (tx_busy) busy_err++;
        end
        prev_we = tx_we;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        pulse_data.delete();
        pulse_cyc.delete();
        consec_err = 0;
        busy_err = 0;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        reset_n  = 1'b0;
        tick(3);
        check("rst_level", int'(level), 0);
        check("rst_wr_full", int'(wr_full), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_tx_we", int'(tx_we), 0);
        check("rst_tx_data", int'(tx_data), 0);
        reset_n = 1'b1;
        tick();
        clear_log();
    endtask

    task automatic write_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            wr_data  = bytes[i];
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_seq(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, pulse_data.size(), exp.size());
        foreach (exp[i])
            if (i < pulse_data.size()) check($sformatf("%s_byte%0d", tag, i), int'(pulse_data[i]), int'(exp[i]));
    endtask

    initial begin
        logic [7:0] exp_q[$];

        // Reset and idle
        tick();
        do_reset();
        tick(5);
        check("idle_pulses", pulse_data.size(), 0);
        check("idle_level", int'(level), 0);
        check("idle_overflow", int'(overflow), 0);

        // Single byte with 16-cycle busy
        busy_len = 16;
        wr_data  = 8'h41;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("single_level1", int'(level), 1);
        check("single_we_early", int'(tx_we), 0);
        tick();
        check("single_we", int'(tx_we), 1);
        check("single_data", int'(tx_data), 8'h41);
        check("single_level0", int'(level), 0);
        tick(30);
        check("single_pulses", pulse_data.size(), 1);

        // Fill and overflow with busy held
        do_reset();
        hold_busy = 1'b1;
        busy_len  = 3;
        for (int i = 0; i < 17; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            tick();
            if (i == 14) check("fill_not_full", int'(wr_full), 0);
            if (i == 15) begin
                check("fill_full", int'(wr_full), 1);
                check("fill_level16", int'(level), 16);
                check("fill_no_ovf", int'(overflow), 0);
            end
        end
        wr_valid = 1'b0;
        check("fill_ovf", int'(overflow), 1);
        check("fill_level_after", int'(level), 16);
        hold_busy = 1'b0;
        tick(150);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        check_seq("fill_drain", exp_q);
        check("fill_drain_level", int'(level), 0);
        check("fill_ovf_sticky", int'(overflow), 1);

        // Full with simultaneous pop
        do_reset();
        hold_busy = 1'b1;
        busy_len  = 4;
        for (int i = 0; i < 16; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        check("pop_full_pre", int'(wr_full), 1);
        hold_busy = 1'b0;
        wr_data   = 8'h55;
        wr_valid  = 1'b1;
        tick();
        check("pop_ovf", int'(overflow), 1);
        check("pop_level15", int'(level), 15);
        check("pop_not_full", int'(wr_full), 0);
        check("pop_we", int'(tx_we), 1);
        wr_data = 8'hAA;
        tick();
        wr_valid = 1'b0;
        check("pop_refill_level", int'(level), 16);
        tick(200);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hAA);
        check_seq("pop_drain", exp_q);

        // Back-to-back handshake: gap = HOLD + WAIT-entry + busy_len + IDLE launch = 7
        do_reset();
        busy_len = 4;
        exp_q = '{8'h61, 8'h62, 8'h63};
        write_seq(exp_q);
        tick(50);
        check_seq("b2b", exp_q);
        if (pulse_cyc.size() == 3) begin
            check("b2b_gap1", pulse_cyc[1] - pulse_cyc[0], 7);
            check("b2b_gap2", pulse_cyc[2] - pulse_cyc[1], 7);
        end
        check("b2b_consec_we", consec_err, 0);
        check("b2b_we_while_busy", busy_err, 0);

        // CR/LF expansion
        do_reset();
        exp_q = '{8'h41, 8'h0A, 8'h42};
        write_seq(exp_q);
        tick(60);
`ifdef RS232OUT_FIFO_CRLF_EN
        exp_q = '{8'h41, 8'h0D, 8'h0A, 8'h42};
`else
        exp_q = '{8'h41, 8'h0A, 8'h42};
`endif
        check_seq("crlf", exp_q);
        check("crlf_level", int'(level), 0);

        // Reset mid-stream: first LF hand-off done, then reset before the rest
        do_reset();
        exp_q = '{8'h0A};
        write_seq(exp_q);
        for (int i = 0; i < 20 && pulse_data.size() == 0; i++) tick();
        check("mid_first_pulse", pulse_data.size(), 1);
        hold_busy = 1'b1;
        tick(2);
        do_reset();
        check("mid_level", int'(level), 0);
        hold_busy = 1'b0;
        tick(10);
        clear_log();
        write_seq(exp_q);
        tick(40);
`ifdef RS232OUT_FIFO_CRLF_EN
        exp_q = '{8'h0D, 8'h0A};
`else
        exp_q = '{8'h0A};
`endif
        check_seq("mid_after", exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
